maze_game_timer: RTL and testbench
==================================

Name: maze_game_timer

Overview:
- BCD stopwatch for the maze game, directly downstream of the Clocks divider.
- Consumes the one-cycle 1 Hz `onePulse` strobe (`tick_1hz`) and counts elapsed play time as MM:SS digits.
- Controlled by start, pause, clear and finish (goal reached) events from the game FSM.
- The digits feed the seven-segment display mux.

Parameters:
- MAX_MIN, 99, saturation minute value (1..99); stop value is MAX_MIN:59.
- LIMIT_MIN, 2, countdown preset minutes (used only with TIMER_COUNTDOWN_EN).
- LIMIT_SEC, 30, countdown preset seconds, 0..59 (used only with TIMER_COUNTDOWN_EN).

Ports:
- clk  in  1  system clock, same domain as Clocks.
- rst  in  1  asynchronous reset, active-low (rst=0 resets).
- tick_1hz  in  1  one-cycle pulse per second (Clocks `onePulse`).
- start  in  1  one-cycle request to begin or resume counting.
- pause  in  1  one-cycle request to freeze counting.
- clear  in  1  one-cycle request to return to the initial value and IDLE.
- finish  in  1  one-cycle request: player reached goal; freeze and latch done.
- min_tens  out  4  BCD minutes tens.
- min_ones  out  4  BCD minutes ones.
- sec_tens  out  4  BCD seconds tens, 0..5.
- sec_ones  out  4  BCD seconds ones.
- running  out  1  high in RUNNING.
- done  out  1  high in DONE.
- overflow  out  1  high if DONE was entered by saturation.
- timeout  out  1  high if DONE was entered by countdown reaching 00:00.

Behaviour:
- Reset (rst=0, asynchronous):
  - Digits load the initial value: 00:00, or LIMIT_MIN:LIMIT_SEC with the countdown feature.
  - State is IDLE; running, done, overflow and timeout are all 0.
- States: IDLE, RUNNING, PAUSED, DONE. All outputs are registered.
- Event priority per cycle: clear > finish > pause > start.
- IDLE:
  - start -> RUNNING.
  - finish -> DONE.
  - pause is ignored.
  - Ticks are ignored.
- RUNNING:
  - tick_1hz=1 advances the count by one second on that edge; new digits are visible the following cycle.
  - pause -> PAUSED.
  - finish -> DONE.
  - start is ignored.
- PAUSED:
  - start -> RUNNING.
  - finish -> DONE.
  - Ticks are ignored.
- DONE:
  - Digits are frozen.
  - Only clear leaves DONE (-> IDLE). start and pause are ignored.
- clear from any state: digits reload the initial value; state -> IDLE; overflow and timeout -> 0. A tick in the same cycle is discarded.
- Simultaneous tick and pause/finish in RUNNING: the tick is counted, and the state change takes effect on the same edge.
- Count-up BCD arithmetic:
  - sec_ones 9->0 carries into sec_tens.
  - sec_tens 5->0 carries into min_ones.
  - min_ones 9->0 carries into min_tens.
- Saturation: a tick at MAX_MIN:59 holds the digits, sets overflow=1 and moves to DONE on the same edge. The digits never wrap.
- Inputs are synchronous to clk. tick_1hz is assumed to be exactly one cycle wide; a held-high tick counts once per cycle.
- No illegal BCD digit value is ever produced.

Optional Feature:
- Macro: TIMER_COUNTDOWN_EN.
- Defined:
  - Reset and clear load LIMIT_MIN:LIMIT_SEC.
  - Ticks in RUNNING decrement the count; a borrow from sec_ones 0 produces 9, and from sec_tens 0 produces 5.
  - The tick that produces 00:00 also moves to DONE with timeout=1 on the same edge.
  - overflow is tied 0.
  - A start issued while the digits are 00:00 goes directly to DONE with timeout=1.
- Undefined: count-up behaviour as described in Behaviour; timeout is tied 0.

Test Plan:
- Reset and start, count-up: release rst, start, then 75 ticks -> digits 01:15, running=1.
- Pause/resume: pause after 10 ticks, apply 5 ticks while PAUSED, start, 3 ticks -> digits 00:13.
- Tick coincident with pause, then finish: at 00:09, tick and pause in the same cycle -> 00:10 and PAUSED; then finish -> done=1, digits stay 00:10; start is ignored.
- Saturation: MAX_MIN=1, start, 120 ticks -> digits 01:59, overflow=1, done=1, running=0.
- Clear priority and async reset: clear and tick in the same cycle at 00:42 -> 00:00, IDLE. Drive rst=0 mid-RUNNING between clk edges -> outputs reset immediately.
- Countdown (TIMER_COUNTDOWN_EN, preset 2:30): start, 1 tick -> 02:29; after 150 ticks -> 00:00, timeout=1, done=1.

Source files
------------

// File: rtl/maze_game_timer.sv
// maze_game_timer: MM:SS BCD play-time stopwatch advanced by the 1 Hz strobe from Clocks.
// Build option TIMER_COUNTDOWN_EN: count down from LIMIT_MIN:LIMIT_SEC and flag timeout at 00:00.
module maze_game_timer #(
  parameter int unsigned MAX_MIN   = 99,
  parameter int unsigned LIMIT_MIN = 2,
  parameter int unsigned LIMIT_SEC = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       finish,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done,
  output logic       overflow,
  output logic       timeout
);

`ifdef TIMER_COUNTDOWN_EN
  localparam bit CountDown = 1'b1;
`else
  localparam bit CountDown = 1'b0;
`endif

  localparam logic [15:0] PresetCnt = {4'(LIMIT_MIN / 10), 4'(LIMIT_MIN % 10),
                                       4'(LIMIT_SEC / 10), 4'(LIMIT_SEC % 10)};
  localparam logic [15:0] InitCnt   = CountDown ? PresetCnt : 16'h0000;
  localparam logic [15:0] MaxCnt    = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10), 4'd5, 4'd9};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Packed digits are {min_tens, min_ones, sec_tens, sec_ones}.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (so != 4'd9) begin
      so = so + 4'd1;
    end else begin
      so = 4'd0;
      if (st != 4'd5) begin
        st = st + 4'd1;
      end else begin
        st = 4'd0;
        if (mo != 4'd9) begin
          mo = mo + 4'd1;
        end else begin
          mo = 4'd0;
          mt = (mt == 4'd9) ? 4'd0 : mt + 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  // Decrement with borrow; 00:00 is held so the count can never wrap.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (v == 16'h0000) begin
      so = 4'd0;
    end else if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        running_q, done_q;
  logic        overflow_q, overflow_d;
  logic        timeout_q, timeout_d;

  logic [15:0] inc_cnt_s, dec_cnt_s, tick_cnt_s;
  logic        at_max_s, tick_end_s, start_zero_s;

  assign inc_cnt_s    = bcd_inc(cnt_q);
  assign dec_cnt_s    = bcd_dec(cnt_q);
  assign at_max_s     = (cnt_q == MaxCnt);
  // Saturation holds the digits; countdown ends on the tick that lands on 00:00.
  assign tick_cnt_s   = CountDown ? dec_cnt_s : (at_max_s ? cnt_q : inc_cnt_s);
  assign tick_end_s   = CountDown ? (dec_cnt_s == 16'h0000) : at_max_s;
  assign start_zero_s = CountDown && (cnt_q == 16'h0000);

  // Next-state and next-count selection with clear > finish > pause > start priority.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    timeout_d  = timeout_q;
    if (clear) begin
      state_d    = ST_IDLE;
      cnt_d      = InitCnt;
      overflow_d = 1'b0;
      timeout_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_PAUSED: begin
          if (finish) begin
            state_d = ST_DONE;
          end else if (start && start_zero_s) begin
            state_d   = ST_DONE;
            timeout_d = 1'b1;
          end else if (start) begin
            state_d = ST_RUNNING;
          end else begin
            state_d = state_q;
          end
        end
        ST_RUNNING: begin
          if (tick_1hz) begin
            cnt_d = tick_cnt_s;
          end else begin
            cnt_d = cnt_q;
          end
          if (tick_1hz && tick_end_s) begin
            state_d    = ST_DONE;
            overflow_d = ~CountDown;
            timeout_d  = CountDown;
          end else if (finish) begin
            state_d = ST_DONE;
          end else if (pause) begin
            state_d = ST_PAUSED;
          end else begin
            state_d = ST_RUNNING;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = InitCnt;
        end
      endcase
    end
  end

  // State, digit and status registers; status flags decode the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= InitCnt;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      running_q  <= (state_d == ST_RUNNING);
      done_q     <= (state_d == ST_DONE);
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  assign min_tens = cnt_q[15:12];
  assign min_ones = cnt_q[11:8];
  assign sec_tens = cnt_q[7:4];
  assign sec_ones = cnt_q[3:0];
  assign running  = running_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_maze_game_timer.sv
// Self-checking bench for maze_game_timer: directed scenarios plus random events
// compared against a seconds-count reference model.
module tb_maze_game_timer;
  localparam int TbMaxMin   = 1;
  localparam int LimMin     = 2;
  localparam int LimSec     = 30;
  localparam int MaxSecs    = TbMaxMin * 60 + 59;
`ifdef TIMER_COUNTDOWN_EN
  localparam bit Down       = 1'b1;
`else
  localparam bit Down       = 1'b0;
`endif
  localparam int InitSecs   = Down ? (LimMin * 60 + LimSec) : 0;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic clk, rst, tick_1hz, start, pause, clear, finish;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic running, done, overflow, timeout;
  logic [19:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  int m_secs, m_state;
  bit m_ovf, m_tmo;

  maze_game_timer #(
    .MAX_MIN  (TbMaxMin),
    .LIMIT_MIN(LimMin),
    .LIMIT_SEC(LimSec)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .tick_1hz(tick_1hz),
    .start   (start),
    .pause   (pause),
    .clear   (clear),
    .finish  (finish),
    .min_tens(min_tens),
    .min_ones(min_ones),
    .sec_tens(sec_tens),
    .sec_ones(sec_ones),
    .running (running),
    .done    (done),
    .overflow(overflow),
    .timeout (timeout)
  );

  assign obs = {min_tens, min_ones, sec_tens, sec_ones, running, done, overflow, timeout};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [19:0] exp_vec();
    int m, s;
    m = m_secs / 60;
    s = m_secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            (m_state == M_RUN), (m_state == M_DONE), m_ovf, m_tmo};
  endfunction

  task automatic model_reset();
    m_secs  = InitSecs;
    m_state = M_IDLE;
    m_ovf   = 1'b0;
    m_tmo   = 1'b0;
  endtask

  task automatic model_step(input bit t, input bit s, input bit p, input bit c, input bit f);
    if (c) begin
      model_reset();
    end else if (m_state == M_IDLE || m_state == M_PAUSE) begin
      if (f) m_state = M_DONE;
      else if (s && Down && m_secs == 0) begin
        m_state = M_DONE;
        m_tmo   = 1'b1;
      end else if (s) m_state = M_RUN;
    end else if (m_state == M_RUN) begin
      if (t) begin
        if (!Down) begin
          if (m_secs == MaxSecs) begin
            m_ovf   = 1'b1;
            m_state = M_DONE;
          end else m_secs++;
        end else begin
          if (m_secs > 0) m_secs--;
          if (m_secs == 0) begin
            m_tmo   = 1'b1;
            m_state = M_DONE;
          end
        end
      end
      if (m_state != M_DONE) begin
        if (f) m_state = M_DONE;
        else if (p) m_state = M_PAUSE;
      end
    end
  endtask

  task automatic step(input bit t, input bit s, input bit p, input bit c, input bit f);
    tick_1hz = t; start = s; pause = p; clear = c; finish = f;
    @(posedge clk);
    model_step(t, s, p, c, f);
    #1;
    tick_1hz = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0; finish = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(input string tag);
    n_checks++;
    assert (obs === exp_vec()) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp_vec());
    end
  endtask

  task automatic check_lit(input string tag, input logic [19:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, want);
    end
  endtask

  initial begin
    rst = 1'b0; tick_1hz = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0; finish = 1'b0;
    model_reset();
    #12;
    check("reset_model");
    check_lit("reset", Down ? {16'h0230, 4'b0000} : {16'h0000, 4'b0000});
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("idle_ignores_tick_pause");

`ifdef TIMER_COUNTDOWN_EN
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(1);
    check_lit("down_first_tick", {16'h0229, 4'b1000});
    ticks(148);
    check_lit("down_0001", {16'h0001, 4'b1000});
    ticks(1);
    check_lit("down_timeout", {16'h0000, 4'b0101});
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_lit("down_done_hold", {16'h0000, 4'b0101});
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_lit("down_clear", {16'h0230, 4'b0000});
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(31);
    check_lit("down_borrow_min", {16'h0159, 4'b1000});
`else
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 75; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_lit("count_75", {16'h0115, 4'b1000});

    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(10);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(5);
    check_lit("paused_hold", {16'h0010, 4'b0000});
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(3);
    check_lit("resume_13", {16'h0013, 4'b1000});

    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(9);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_lit("tick_with_pause", {16'h0010, 4'b0000});
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_lit("finish_done", {16'h0010, 4'b0100});
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_lit("done_ignores_start", {16'h0010, 4'b0100});

    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(119);
    check_lit("at_max", {16'h0159, 4'b1000});
    ticks(1);
    check_lit("saturate", {16'h0159, 4'b0110});
    ticks(3);
    check_lit("saturate_hold", {16'h0159, 4'b0110});

    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(42);
    check_lit("count_42", {16'h0042, 4'b1000});
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check_lit("clear_beats_tick", {16'h0000, 4'b0000});
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(5);
`endif
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check("async_reset_model");
    check_lit("async_reset", Down ? {16'h0230, 4'b0000} : {16'h0000, 4'b0000});
    #2;
    rst = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 199) == 0, $urandom_range(0, 149) == 0);
      check("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
